serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
Bit-serial adder controller that time-shares a single one-bit full-adder cell (the existing gate-level sum/carry cell) across a WIDTH-bit addition. One operand bit is processed per clock, LSB first, with a registered carry fed back into the cell's carry input. It sits between a requester with a start/done handshake and the one-bit adder datapath. It is used where area matters more than latency.

Parameters:
WIDTH, 8, operand and result width in bits; legal range is 2..32.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request pulse; sampled only in IDLE or DONE.
a  input  WIDTH  operand A; captured on an accepted start.
b  input  WIDTH  operand B; captured on an accepted start.
cin  input  1  carry-in; captured on an accepted start.
busy  output  1  high while the addition is in progress (state RUN).
done  output  1  one-cycle completion strobe (state DONE).
sum  output  WIDTH  registered result; updated only at completion.
cout  output  1  registered final carry-out; updated only at completion.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state goes to IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Operand shift registers, carry register and bit counter are all cleared.
  - Reset takes effect immediately, including mid-RUN; any partial result is discarded.
- Internal state:
  - shift_a and shift_b: WIDTH-bit shift registers.
  - acc: WIDTH-bit partial-sum register.
  - carry: 1-bit carry register.
  - cnt: bit counter, width $clog2(WIDTH)+1.
- FSM states:
  - IDLE: busy=0, done=0. On start=1: load shift_a<=a, shift_b<=b, carry<=cin, cnt<=0, acc<=0; go to RUN.
  - RUN: busy=1, done=0. On every edge:
    - The full-adder cell is driven with x=shift_a[0], y=shift_b[0], cin=carry.
    - carry <= cell carry-out.
    - acc <= {cell sum, acc[WIDTH-1:1]}, i.e. right shift with the new bit entering at the MSB.
    - shift_a and shift_b shift right by 1, zero-filled.
    - cnt <= cnt+1.
    - On the edge where cnt==WIDTH-1: sum <= final acc value including this bit, cout <= cell carry-out; go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle.
    - start=1 is accepted exactly as in IDLE and goes directly to RUN.
    - Otherwise go to IDLE.
- Latency: start accepted at edge E. Bits are processed on edges E+1..E+WIDTH. done=1 in the cycle after edge E+WIDTH, so sum/cout are valid when done rises.
- Handshake rules:
  - start is ignored while busy=1. No queuing, and operands are not re-captured.
  - a, b and cin need to be valid only in the accepting cycle.
  - sum and cout hold their last result until the next completion or reset. They do not change during RUN.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). Unsigned; no overflow flag.
- Back-to-back operation: start held high continuously gives one result every WIDTH+1 cycles (each DONE cycle accepts the next start).
- Combinational paths: none from inputs to outputs; all outputs are registered or decoded from state.

Test Plan:
- WIDTH=8, reset then start with a=0x0F, b=0x01, cin=0 -> busy high for 8 cycles; done one cycle later; sum=0x10, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1; a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
- Accept a=0x12, b=0x34, then pulse start with a=0xAA, b=0x55 during RUN -> second request ignored; sum=0x46, cout=0; done pulses exactly once.
- Accept a=0x80, b=0x80, cin=0, assert rst_n=0 after 4 RUN edges -> immediately busy=0, done=0, sum=0, cout=0; after release the FSM idles until a new start.
- Hold start=1 continuously with a=0x01, b=0x01 -> done pulses every 9 cycles, sum=0x02 each time, busy low only during the DONE cycles.
- Random/exhaustive check (WIDTH=4, all 512 a/b/cin combinations) against reference a+b+cin -> {cout,sum} matches on every done pulse.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell is reused for every bit
// of a WIDTH-bit addition, LSB first, with the carry held in a register
// between bits. The result appears WIDTH+1 cycles after an accepted start.
//
// Handshake: start is sampled only while the FSM is in IDLE or DONE; a, b and
// cin are captured in that same cycle and need not be held afterwards. busy
// is high for the WIDTH cycles of RUN and start is ignored then. done is a
// one-cycle strobe, and sum/cout are already valid when it rises. sum/cout
// hold their value until the next completion or reset.

// Gate-level one-bit full-adder cell.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [1:0]       state_dbg
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shift_a;
    logic [WIDTH-1:0] shift_b;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;
    logic             accept;
    logic             last_bit;

    // Shared one-bit datapath: current LSBs plus the fed-back carry.
    fa_cell u_fa (
        .x  (shift_a[0]),
        .y  (shift_b[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign last_bit  = (cnt == CW'(WIDTH - 1));
    assign state_dbg = state;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: DONE behaves like IDLE for a new start.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded straight from the state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: capture on accept, one bit per RUN edge, publish on the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_a <= '0;
            shift_b <= '0;
            acc     <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else if (accept) begin
            shift_a <= a;
            shift_b <= b;
            carry   <= cin;
            cnt     <= '0;
            acc     <= '0;
        end else if (state == RUN) begin
            shift_a <= {1'b0, shift_a[WIDTH-1:1]};
            shift_b <= {1'b0, shift_b[WIDTH-1:1]};
            acc     <= {fa_s, acc[WIDTH-1:1]};
            carry   <= fa_co;
            cnt     <= cnt + CW'(1);
            if (last_bit) begin
                sum  <= {fa_s, acc[WIDTH-1:1]};
                cout <= fa_co;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl: a WIDTH=8 instance for directed, table and
// random tests, and a WIDTH=4 instance for the exhaustive sweep. Expected
// results come from plain integer addition of the operands.
module tb_serial_adder_ctrl;
    logic       clk;
    logic       rst_n;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic [1:0] state_dbg8;

    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;
    logic [1:0] state_dbg4;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] exp8_q[$];
    logic [4:0] exp4_q[$];

    logic [1:0] idle_code8, idle_code4;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
    } vec_t;

    vec_t tbl[6];

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .state_dbg(state_dbg8)
    );

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .state_dbg(state_dbg4)
    );

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboards: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin : mon8
        logic [8:0] e;
        if (rst_n && done8) begin
            if (exp8_q.size() == 0) begin
                check("sb8_spurious_done", 1, 0);
            end else begin
                e = exp8_q.pop_front();
                check("sb8_result", {23'd0, cout8, sum8}, {23'd0, e});
            end
        end
    end

    always @(negedge clk) begin : mon4
        logic [4:0] e;
        if (rst_n && done4) begin
            if (exp4_q.size() == 0) begin
                check("sb4_spurious_done", 1, 0);
            end else begin
                e = exp4_q.pop_front();
                check("sb4_result", {27'd0, cout4, sum4}, {27'd0, e});
            end
        end
    end

    // Driver for the 8-bit instance; returns at the negedge where done is seen.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c);
        int         n;
        int         nb;
        int         sum_changes;
        logic [8:0] prev;
        start8 = 1'b1;
        a8     = a;
        b8     = b;
        cin8   = c;
        exp8_q.push_back(9'(a) + 9'(b) + 9'(c));
        prev   = {cout8, sum8};
        @(negedge clk);
        start8 = 1'b0;
        a8     = 8'($urandom);
        b8     = 8'($urandom);
        cin8   = 1'($urandom);
        n = 0; nb = 0; sum_changes = 0;
        while (!done8 && n < 40) begin
            if (busy8) nb++;
            if ({cout8, sum8} !== prev) sum_changes++;
            @(negedge clk);
            n++;
        end
        check("lat8_cycles_to_done", n, 8);
        check("lat8_busy_cycles", nb, 8);
        check("sum8_stable_in_run", sum_changes, 0);
    endtask

    // Driver for the 4-bit instance; back-to-back capable.
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic c);
        int n;
        start4 = 1'b1;
        a4     = a;
        b4     = b;
        cin4   = c;
        exp4_q.push_back(5'(a) + 5'(b) + 5'(c));
        @(negedge clk);
        start4 = 1'b0;
        n = 0;
        while (!done4 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("lat4_cycles_to_done", n, 4);
    endtask

    initial begin
        int t[3];
        int nd;
        int bad;
        int n;

        tbl[0] = '{a: 8'h0F, b: 8'h01, cin: 1'b0, s: 8'h10, co: 1'b0};
        tbl[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, s: 8'h00, co: 1'b1};
        tbl[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, s: 8'hFF, co: 1'b1};
        tbl[3] = '{a: 8'h00, b: 8'h00, cin: 1'b1, s: 8'h01, co: 1'b0};
        tbl[4] = '{a: 8'h12, b: 8'h34, cin: 1'b0, s: 8'h46, co: 1'b0};
        tbl[5] = '{a: 8'hA5, b: 8'h5A, cin: 1'b1, s: 8'h00, co: 1'b1};

        rst_n  = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_busy8", busy8, 0);
        check("rst_done8", done8, 0);
        check("rst_sum8", sum8, 0);
        check("rst_cout8", cout8, 0);
        check("rst_busy4", busy4, 0);
        check("rst_sum4", sum4, 0);
        idle_code8 = state_dbg8;
        idle_code4 = state_dbg4;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven vectors, each followed by a return to idle.
        for (int i = 0; i < 6; i++) begin
            run8(tbl[i].a, tbl[i].b, tbl[i].cin);
            check("tbl_sum", sum8, tbl[i].s);
            check("tbl_cout", cout8, tbl[i].co);
            @(negedge clk);
            check("tbl_done_one_cycle", done8, 0);
            check("tbl_idle_busy", busy8, 0);
            check("tbl_sum_held", sum8, tbl[i].s);
        end

        // start during RUN must be ignored.
        start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
        exp8_q.push_back(9'h046);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ign_done_seen", done8, 1);
        check("ign_sum", sum8, 8'h46);
        check("ign_cout", cout8, 0);
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done8 || busy8) nd++;
        end
        check("ign_single_done", nd, 0);

        // Reset in the middle of RUN discards everything at once.
        start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        check("midrun_busy_before", busy8, 1);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_busy", busy8, 0);
        check("midrun_rst_done", done8, 0);
        check("midrun_rst_sum", sum8, 0);
        check("midrun_rst_cout", cout8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy8 || done8 || state_dbg8 !== idle_code8) bad++;
            if (state_dbg4 !== idle_code4) bad++;
        end
        check("post_rst_stays_idle", bad, 0);
        check("post_rst_sum", sum8, 0);

        // start held high: one result every WIDTH+1 cycles.
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0;
        repeat (3) exp8_q.push_back(9'h002);
        nd = 0; bad = 0;
        for (int cyc = 1; cyc <= 60 && nd < 3; cyc++) begin
            @(negedge clk);
            if (busy8 === done8) bad++;
            if (done8) begin
                t[nd] = cyc;
                nd++;
                check("b2b_sum", sum8, 8'h02);
                if (nd == 3) start8 = 1'b0;
            end
        end
        start8 = 1'b0;
        check("b2b_done_count", nd, 3);
        check("b2b_first_done", t[0], 9);
        check("b2b_period1", t[1] - t[0], 9);
        check("b2b_period2", t[2] - t[1], 9);
        check("b2b_busy_vs_done", bad, 0);
        @(negedge clk);
        check("b2b_back_to_idle", busy8 | done8, 0);

        // Random operands against the arithmetic model.
        for (int i = 0; i < 100; i++) begin
            run8(8'($urandom), 8'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        @(negedge clk);

        // Exhaustive sweep on the 4-bit instance, chained through DONE.
        for (int i = 0; i < 512; i++) begin
            run4(4'(i >> 5), 4'(i >> 1), 1'(i));
        end
        @(negedge clk);
        check("q8_drained", exp8_q.size(), 0);
        check("q4_drained", exp4_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Overall time limit.
    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
